// File: rtl/i2c_wb_pkg.sv
// rtl/i2c_wb_pkg.sv - register map and bit positions for the I2C Wishbone bridge
package i2c_wb_pkg;

  localparam logic [2:0] REG_RXDATA = 3'd0;
  localparam logic [2:0] REG_TXDATA = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;

  // Event bits live at STATUS[13:8] and CTRL[13:8] in this order
  localparam int ST_LSB   = 8;
  localparam int EV_W     = 6;
  localparam int EV_WSTOP = 0;
  localparam int EV_RSTOP = 1;
  localparam int EV_RERR  = 2;
  localparam int EV_RXOVF = 3;
  localparam int EV_RXUND = 4;
  localparam int EV_TXOVF = 5;

  localparam int CTRL_RXFLUSH = 16;
  localparam int CTRL_TXFLUSH = 17;

  localparam logic [6:0] DEF_RESET_ADDR = 7'h10;

  typedef logic [EV_W-1:0] ev_t;

endpackage

// File: rtl/i2c_sync_fifo.sv
// rtl/i2c_sync_fifo.sv - first-word-fall-through synchronous FIFO with flush and count
module i2c_sync_fifo #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = r_count[AW];
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = empty ? '0 : r_mem[r_rptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

  // Flush overrides any push/pop landing in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/i2c_wb_bridge.sv
// rtl/i2c_wb_bridge.sv - Wishbone slave front end with RX/TX FIFOs and sticky IRQ for the I2C PHY
module i2c_wb_bridge
  import i2c_wb_pkg::*;
#(
  parameter int         AW         = 4,
  parameter logic [6:0] RESET_ADDR = DEF_RESET_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        irq,
  output logic [6:0]  phy_addr,
  input  logic        phy_wstop,
  input  logic        phy_rstop,
  input  logic        phy_rerr,
  output logic        phy_full,
  input  logic        phy_push,
  input  logic [31:0] phy_dout,
  output logic        phy_empty,
  input  logic        phy_pop,
  output logic [31:0] phy_din
);

  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_irq;
  logic [6:0]  r_addr;
  ev_t         r_en;
  ev_t         r_sticky;

  logic        w_req;
  logic        w_rd;
  logic        w_wr;
  logic [2:0]  w_reg;
  logic        w_rx_pop;
  logic        w_tx_push;
  logic        w_ctrl_wr;
  logic        w_rx_flush;
  logic        w_tx_flush;
  logic [31:0] w_rx_dout;
  logic        w_rx_empty;
  logic        w_tx_full;
  logic [AW:0] w_rx_cnt;
  logic [AW:0] w_tx_cnt;
  ev_t         w_set;
  ev_t         w_clr;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_unused_ok;

  assign w_unused_ok = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0]};

  // The request cycle is the one just before ack; all side effects commit on that edge
  assign w_req      = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_rd       = w_req & ~wb_we_i;
  assign w_wr       = w_req & wb_we_i;
  assign w_reg      = wb_adr_i[4:2];
  assign w_rx_pop   = w_rd & (w_reg == REG_RXDATA);
  assign w_tx_push  = w_wr & (w_reg == REG_TXDATA);
  assign w_ctrl_wr  = w_wr & (w_reg == REG_CTRL);
  assign w_rx_flush = w_ctrl_wr & wb_dat_i[CTRL_RXFLUSH];
  assign w_tx_flush = w_ctrl_wr & wb_dat_i[CTRL_TXFLUSH];
  assign w_clr      = (w_wr && (w_reg == REG_STATUS)) ? wb_dat_i[ST_LSB +: EV_W] : '0;

  i2c_sync_fifo #(.AW(AW), .DW(32)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (w_rx_flush),
    .push  (phy_push),
    .din   (phy_dout),
    .pop   (w_rx_pop),
    .dout  (w_rx_dout),
    .full  (phy_full),
    .empty (w_rx_empty),
    .count (w_rx_cnt)
  );

  i2c_sync_fifo #(.AW(AW), .DW(32)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (w_tx_flush),
    .push  (w_tx_push),
    .din   (wb_dat_i),
    .pop   (phy_pop),
    .dout  (phy_din),
    .full  (w_tx_full),
    .empty (phy_empty),
    .count (w_tx_cnt)
  );

  always_comb begin
    w_set           = '0;
    w_set[EV_WSTOP] = phy_wstop;
    w_set[EV_RSTOP] = phy_rstop;
    w_set[EV_RERR]  = phy_rerr;
    w_set[EV_RXOVF] = phy_push & phy_full;
    w_set[EV_RXUND] = w_rx_pop & w_rx_empty;
    w_set[EV_TXOVF] = w_tx_push & w_tx_full;
  end

  always_comb begin
    w_status                  = '0;
    w_status[AW:0]            = w_rx_cnt;
    w_status[AW+16:16]        = w_tx_cnt;
    w_status[ST_LSB +: EV_W]  = r_sticky;
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_RXDATA: w_rdata = w_rx_dout;
      REG_STATUS: w_rdata = w_status;
      REG_CTRL: begin
        w_rdata[6:0]           = r_addr;
        w_rdata[ST_LSB +: EV_W] = r_en;
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_irq    <= 1'b0;
      r_addr   <= RESET_ADDR;
      r_en     <= '0;
      r_sticky <= '0;
    end else begin
      r_ack    <= w_req;
      r_dat    <= w_rd ? w_rdata : '0;
      r_sticky <= (r_sticky & ~w_clr) | w_set;
      r_irq    <= |(r_sticky & r_en);
      if (w_ctrl_wr) begin
        r_addr <= wb_dat_i[6:0];
        r_en   <= wb_dat_i[ST_LSB +: EV_W];
      end
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign irq      = r_irq;
  assign phy_addr = r_addr;

endmodule

// File: tb/tb_i2c_wb_bridge.sv
// tb/tb_i2c_wb_bridge.sv - directed self-checking bench for i2c_wb_bridge
module tb_i2c_wb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  logic        irq;
  logic [6:0]  phy_addr;
  logic        phy_wstop = 1'b0;
  logic        phy_rstop = 1'b0;
  logic        phy_rerr = 1'b0;
  logic        phy_full;
  logic        phy_push = 1'b0;
  logic [31:0] phy_dout = '0;
  logic        phy_empty;
  logic        phy_pop = 1'b0;
  logic [31:0] phy_din;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] q;

  i2c_wb_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_we_i   (wb_we_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o),
    .wb_rty_o  (wb_rty_o),
    .irq       (irq),
    .phy_addr  (phy_addr),
    .phy_wstop (phy_wstop),
    .phy_rstop (phy_rstop),
    .phy_rerr  (phy_rerr),
    .phy_full  (phy_full),
    .phy_push  (phy_push),
    .phy_dout  (phy_dout),
    .phy_empty (phy_empty),
    .phy_pop   (phy_pop),
    .phy_din   (phy_din)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Starts 1 time unit after a rising edge; side pulses line up with the request edge
  task automatic wb_xfer(input logic we, input logic [2:0] r, input logic [31:0] d,
                         input logic wstop_p, input logic pop_p, input logic push_p,
                         output logic [31:0] rd);
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    wb_we_i   = we;
    wb_adr_i  = {27'd0, r, 2'b00};
    wb_dat_i  = d;
    phy_wstop = wstop_p;
    phy_pop   = pop_p;
    phy_push  = push_p;
    @(posedge clk); #1;
    phy_wstop = 1'b0;
    phy_pop   = 1'b0;
    phy_push  = 1'b0;
    check("ack", {31'd0, wb_ack_o}, 32'd1);
    rd = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rx_push(input logic [31:0] v);
    phy_push = 1'b1;
    phy_dout = v;
    @(posedge clk); #1;
    phy_push = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1. reset state and RX underflow
    check("rst_empty", {31'd0, phy_empty}, 32'd1);
    check("rst_full", {31'd0, phy_full}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_din", phy_din, 32'd0);
    check("rst_addr", {25'd0, phy_addr}, 32'h10);
    wb_xfer(1'b0, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, q); check("rst_status", q, 32'h0);
    wb_xfer(1'b0, 3'd3, 32'd0, 1'b0, 1'b0, 1'b0, q); check("rst_ctrl", q, 32'h10);
    wb_xfer(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, q); check("rxund_data", q, 32'h0);
    wb_xfer(1'b0, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, q); check("rxund_status", q, 32'h1000);
    wb_xfer(1'b1, 3'd2, 32'h3F00, 1'b0, 1'b0, 1'b0, q);
    wb_xfer(1'b0, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, q); check("w1c_all", q, 32'h0);

    // 2. TX writes and PHY pop
    wb_xfer(1'b1, 3'd1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, q);
    wb_xfer(1'b1, 3'd1, 32'h0000_0002, 1'b0, 1'b0, 1'b0, q);
    wb_xfer(1'b0, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, q); check("tx_cnt2", q, 32'h0002_0000);
    check("tx_head", phy_din, 32'hA5A5_0001);
    check("tx_notempty", {31'd0, phy_empty}, 32'd0);
    phy_pop = 1'b1; @(posedge clk); #1; phy_pop = 1'b0;
    check("tx_head2", phy_din, 32'h2);
    phy_pop = 1'b1; @(posedge clk); #1;
    check("tx_empty", {31'd0, phy_empty}, 32'd1);
    @(posedge clk); #1; phy_pop = 1'b0;
    wb_xfer(1'b0, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, q); check("tx_pop_empty", q, 32'h0);

    // 3. RX fill, overflow, ordered drain
    for (int i = 0; i < 16; i++) rx_push(i);
    check("rx_full", {31'd0, phy_full}, 32'd1);
    rx_push(32'h99);
    wb_xfer(1'b0, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, q); check("rxovf_status", q, 32'h0810);
    for (int i = 0; i < 16; i++) begin
      wb_xfer(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, q);
      check($sformatf("rx_data%0d", i), q, i);
    end
    wb_xfer(1'b1, 3'd2, 32'h3F00, 1'b0, 1'b0, 1'b0, q);
    wb_xfer(1'b0, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, q); check("rx_drained", q, 32'h0);

    // 4. interrupt path
    wb_xfer(1'b1, 3'd3, 32'h0000_0110, 1'b0, 1'b0, 1'b0, q);
    wb_xfer(1'b0, 3'd3, 32'd0, 1'b0, 1'b0, 1'b0, q); check("ctrl_en", q, 32'h110);
    phy_wstop = 1'b1; @(posedge clk); #1; phy_wstop = 1'b0;
    check("irq_lat1", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq_lat2", {31'd0, irq}, 32'd1);
    wb_xfer(1'b1, 3'd2, 32'h100, 1'b0, 1'b0, 1'b0, q);
    check("irq_clear", {31'd0, irq}, 32'd0);
    wb_xfer(1'b1, 3'd2, 32'h100, 1'b1, 1'b0, 1'b0, q);
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    wb_xfer(1'b0, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, q); check("set_wins_status", q, 32'h100);
    wb_xfer(1'b1, 3'd3, 32'h10, 1'b0, 1'b0, 1'b0, q);
    wb_xfer(1'b1, 3'd2, 32'h3F00, 1'b0, 1'b0, 1'b0, q);

    // 5. TX flush beats a same-cycle pop
    for (int i = 0; i < 3; i++) wb_xfer(1'b1, 3'd1, 32'h10 + i, 1'b0, 1'b0, 1'b0, q);
    wb_xfer(1'b0, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, q); check("tx_cnt3", q, 32'h0003_0000);
    wb_xfer(1'b1, 3'd3, 32'h0002_0010, 1'b0, 1'b1, 1'b0, q);
    wb_xfer(1'b0, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, q); check("tx_flushed", q, 32'h0);
    check("tx_flush_empty", {31'd0, phy_empty}, 32'd1);
    check("tx_flush_din", phy_din, 32'h0);
    wb_xfer(1'b0, 3'd3, 32'd0, 1'b0, 1'b0, 1'b0, q); check("ctrl_flush_rd0", q, 32'h10);

    // 6. simultaneous RX push and pop at count 15
    for (int i = 0; i < 15; i++) rx_push(32'd100 + i);
    wb_xfer(1'b0, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, q); check("rx_cnt15", q, 32'h0F);
    phy_dout = 32'd200;
    wb_xfer(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b1, q); check("rx_pp_data", q, 32'd100);
    wb_xfer(1'b0, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, q); check("rx_pp_status", q, 32'h0F);
    wb_xfer(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, q); check("rx_pp_next", q, 32'd101);
    wb_xfer(1'b1, 3'd3, 32'h0001_0010, 1'b0, 1'b0, 1'b0, q);
    wb_xfer(1'b0, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, q); check("rx_flushed", q, 32'h0);

    // 7. TX overflow and unmapped offsets
    for (int i = 0; i < 17; i++) wb_xfer(1'b1, 3'd1, 32'h100 + i, 1'b0, 1'b0, 1'b0, q);
    wb_xfer(1'b0, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, q); check("txovf_status", q, 32'h0010_2000);
    check("txovf_head", phy_din, 32'h100);
    wb_xfer(1'b0, 3'd5, 32'd0, 1'b0, 1'b0, 1'b0, q); check("reg5_zero", q, 32'h0);
    check("err_rty", {30'd0, wb_err_o, wb_rty_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
